// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester handshakes (IF, LSU) and the byte-wide memory bus
// bundled for the mem_ctrl controller. The controller uses the slave modport;
// the requesters and the RAM/IO model use the master modport.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    // load/store port
    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic              ls_signed;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    // byte-serial memory bus
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_signed, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_signed, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller serving the instruction fetch and
// load/store requesters over one 8-bit bus with a one-cycle read return.
// 1/2/4-byte requests become sequential byte accesses; LSU wins arbitration.
// Optional feature: define MEM_CTRL_IF_FLUSH_EN to add flush_in, which aborts
// an in-flight IF read (and drops an IF request sampled in IDLE).
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rdy_in,
`ifdef MEM_CTRL_IF_FLUSH_EN
    input  logic       flush_in,
`endif
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;

    // latched request
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              port_ls_q, port_ls_d;   // 1 = LSU owns the transfer
    logic [2:0]        n_q, n_d;               // bytes in transfer (1/2/4)

    // transfer progress
    logic [2:0]        a_cnt_q, a_cnt_d;       // next byte index to address
    logic [2:0]        cap_cnt_q, cap_cnt_d;   // bytes captured so far
    logic              mem_vld_q, mem_vld_d;   // mem_a holds a live read this cycle
    logic              rd_pend_q, rd_pend_d;   // mem_din carries the byte addressed last cycle
    logic              rdy_q;                  // rdy_in one cycle ago, to spot resume
    logic [31:0]       rbuf_q, rbuf_d;

    // registered outputs
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    // scratch for the next-state logic
    logic              acc, acc_wr, flush;
    logic [31:0]       word;

    function automatic logic [2:0] size_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte/half loads are always re-extended so stale upper bytes never leak.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz, input logic sg);
        case (sz)
            2'b00:   return {{24{sg & w[7]}}, w[7:0]};
            2'b01:   return {{16{sg & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

`ifdef MEM_CTRL_IF_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    // Next-state and next-output logic for the whole controller.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        port_ls_d  = port_ls_q;
        n_d        = n_q;
        a_cnt_d    = a_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        mem_vld_d  = mem_vld_q;
        rd_pend_d  = rd_pend_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        acc        = 1'b0;
        acc_wr     = 1'b0;
        word       = rbuf_q;

        case (state_q)
            IDLE: begin
                // bus stays quiet while idle: no speculative IO reads
                mem_a_d    = '0;
                mem_dout_d = '0;
                mem_wr_d   = 1'b0;
                mem_vld_d  = 1'b0;
                if (rdy_in) begin
                    if (bus.ls_req) begin
                        acc       = 1'b1;
                        acc_wr    = bus.ls_wr;
                        addr_d    = bus.ls_addr;
                        wdata_d   = bus.ls_wdata;
                        size_d    = bus.ls_size;
                        sgn_d     = bus.ls_signed;
                        port_ls_d = 1'b1;
                        n_d       = size_n(bus.ls_size);
                    end else if (bus.if_req && !flush) begin
                        acc       = 1'b1;
                        addr_d    = bus.if_addr;
                        size_d    = 2'b10;
                        sgn_d     = 1'b0;
                        port_ls_d = 1'b0;
                        n_d       = 3'd4;
                    end
                end
                if (acc) begin
                    // byte 0 goes on the bus in the cycle after accept
                    a_cnt_d   = 3'd1;
                    cap_cnt_d = 3'd0;
                    rd_pend_d = 1'b0;
                    rbuf_d    = '0;
                    mem_a_d   = addr_d;
                    mem_vld_d = 1'b1;
                    if (acc_wr) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = wdata_d[7:0];
                        state_d    = WRITE;
                    end else begin
                        state_d    = READ;
                    end
                end
            end

            READ: begin
                if (flush && !port_ls_q) begin
                    // mispredicted fetch: drop it without a done pulse
                    state_d   = IDLE;
                    mem_a_d   = '0;
                    mem_vld_d = 1'b0;
                    rd_pend_d = 1'b0;
                end else if (rdy_in) begin
                    if (!rdy_q) begin
                        // first cycle back from a stall: the in-flight return was
                        // lost, so restart addressing at the oldest missing byte
                        a_cnt_d   = cap_cnt_q + 3'd1;
                        mem_a_d   = addr_q + ADDR_W'(cap_cnt_q);
                        mem_vld_d = 1'b1;
                        rd_pend_d = 1'b0;
                    end else begin
                        if (rd_pend_q) begin
                            word[{cap_cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
                            rbuf_d    = word;
                            cap_cnt_d = cap_cnt_q + 3'd1;
                        end
                        if (a_cnt_q < n_q) begin
                            mem_a_d   = addr_q + ADDR_W'(a_cnt_q);
                            a_cnt_d   = a_cnt_q + 3'd1;
                            mem_vld_d = 1'b1;
                        end else begin
                            mem_a_d   = '0;
                            mem_vld_d = 1'b0;
                        end
                        rd_pend_d = mem_vld_q;
                        if (rd_pend_q && (cap_cnt_q == n_q - 3'd1)) begin
                            state_d   = DONE;
                            mem_a_d   = '0;
                            mem_vld_d = 1'b0;
                            rd_pend_d = 1'b0;
                            if (port_ls_q) begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = extend(word, size_q, sgn_q);
                            end else begin
                                if_done_d  = 1'b1;
                                if_data_d  = word;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                // a stalled byte is simply re-presented once rdy_in returns
                if (rdy_in) begin
                    if (a_cnt_q == n_q) begin
                        state_d    = DONE;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                        ls_done_d  = 1'b1;
                    end else begin
                        mem_a_d    = addr_q + ADDR_W'(a_cnt_q);
                        mem_dout_d = wdata_q[{a_cnt_q[1:0], 3'b000} +: 8];
                        a_cnt_d    = a_cnt_q + 3'd1;
                    end
                end
            end

            DONE: begin
                if (rdy_in) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            port_ls_q  <= 1'b0;
            n_q        <= '0;
            a_cnt_q    <= '0;
            cap_cnt_q  <= '0;
            mem_vld_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rdy_q      <= 1'b1;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            port_ls_q  <= port_ls_d;
            n_q        <= n_d;
            a_cnt_q    <= a_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            mem_vld_q  <= mem_vld_d;
            rd_pend_q  <= rd_pend_d;
            rdy_q      <= rdy_in;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    // the debug host owns the bus while rdy_in is low, so never write then
    assign bus.mem_wr   = mem_wr_q & rdy_in;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl. Stimulus pushes the
// expected done responses and bus writes; negedge monitors pop and compare.
module tb_mem_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
`ifdef MEM_CTRL_IF_FLUSH_EN
    logic flush = 1'b0;
`endif

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
`ifdef MEM_CTRL_IF_FLUSH_EN
        .flush_in (flush),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [31:0] data; int cyc; bit chk_data; } done_exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_exp_t;

    done_exp_t if_q[$];
    done_exp_t ls_q[$];
    wr_exp_t   wr_q[$];

    // RAM/IO model: one-cycle registered read return, writes on mem_wr
    logic [7:0] ram [0:262143];
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[17:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_if(input logic [31:0] d, input int c);
        done_exp_t e;
        e.data = d; e.cyc = c; e.chk_data = 1'b1;
        if_q.push_back(e);
    endtask

    task automatic push_ls(input logic [31:0] d, input int c, input bit chk);
        done_exp_t e;
        e.data = d; e.cyc = c; e.chk_data = chk;
        ls_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        wr_q.push_back(e);
    endtask

    // Monitors: compare every done pulse and every bus write against the queues.
    always @(negedge clk) begin
        done_exp_t e;
        wr_exp_t   w;
        if (bus.ls_done) begin
            if (ls_q.size() == 0) check("ls_done unexpected", 32'(bus.ls_done), 32'd0);
            else begin
                e = ls_q.pop_front();
                if (e.cyc >= 0) check("ls_done cycle", cyc, e.cyc);
                if (e.chk_data) check("ls_rdata", bus.ls_rdata, e.data);
            end
        end
        if (bus.if_done) begin
            if (if_q.size() == 0) check("if_done unexpected", 32'(bus.if_done), 32'd0);
            else begin
                e = if_q.pop_front();
                if (e.cyc >= 0) check("if_done cycle", cyc, e.cyc);
                check("if_data", bus.if_data, e.data);
            end
        end
        if (bus.mem_wr) begin
            if (wr_q.size() == 0) check("mem_wr unexpected", 32'(bus.mem_wr), 32'd0);
            else begin
                w = wr_q.pop_front();
                check("wr addr", bus.mem_a, w.addr);
                check("wr data", 32'(bus.mem_dout), 32'(w.data));
                if (w.cyc >= 0) check("wr cycle", cyc, w.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit ls);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = ls ? bus.ls_done : bus.if_done;
        end
        if (!got) check(ls ? "ls_done timeout" : "if_done timeout",
                        32'(ls ? bus.ls_done : bus.if_done), 32'd1);
    endtask

    task automatic lsu(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
        bus.ls_wr = wr; bus.ls_size = sz; bus.ls_signed = sg;
        bus.ls_addr = a; bus.ls_wdata = wd; bus.ls_req = 1'b1;
        wait_done(1'b1);
        bus.ls_req = 1'b0;
    endtask

    task automatic ifetch(input logic [31:0] a);
        bus.if_addr = a; bus.if_req = 1'b1;
        wait_done(1'b0);
        bus.if_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_a"},    bus.mem_a, 32'd0);
        check({tag, " mem_wr"},   32'(bus.mem_wr), 32'd0);
        check({tag, " mem_dout"}, 32'(bus.mem_dout), 32'd0);
        check({tag, " if_done"},  32'(bus.if_done), 32'd0);
        check({tag, " ls_done"},  32'(bus.ls_done), 32'd0);
        check({tag, " if_data"},  bus.if_data, 32'd0);
        check({tag, " ls_rdata"}, bus.ls_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  c0;
        bit  seen;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram['h100] = 8'h13; ram['h101] = 8'h00; ram['h102] = 8'h00; ram['h103] = 8'h93;
        ram['h104] = 8'h37; ram['h105] = 8'h05; ram['h106] = 8'h00; ram['h107] = 8'h10;
        ram['h200] = 8'h80; ram['h201] = 8'h11; ram['h202] = 8'h22; ram['h203] = 8'h33;
        ram['h1F0] = 8'h34; ram['h1F1] = 8'h92;
        ram['h300] = 8'h5A; ram['h301] = 8'hC3; ram['h302] = 8'h0F; ram['h303] = 8'hF0;
        ram['h3FFFF] = 8'hAA; ram[1] = 8'h02; ram[2] = 8'h03; ram[0] = 8'h01;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'b00; bus.ls_signed = 1'b0;
        bus.ls_addr = '0; bus.ls_wdata = '0;

        // reset state
        #2;
        check_reset_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // IF word read, address walk and latency
        c0 = cyc;
        push_if(32'h93000013, c0 + 6);
        fork
            ifetch(32'h100);
            begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("if mem_a walk", bus.mem_a, 32'h100 + 32'(k));
                end
            end
        join
        tick();

        // byte loads, signed and unsigned
        c0 = cyc; push_ls(32'hFFFFFF80, c0 + 3, 1'b1); lsu(1'b0, 2'b00, 1'b1, 32'h200, 32'h0); tick();
        c0 = cyc; push_ls(32'h00000080, c0 + 3, 1'b1); lsu(1'b0, 2'b00, 1'b0, 32'h200, 32'h0); tick();
        // signed half load
        c0 = cyc; push_ls(32'hFFFF9234, c0 + 4, 1'b1); lsu(1'b0, 2'b01, 1'b1, 32'h1F0, 32'h0); tick();
        // word load wrapping past the top of the address space
        c0 = cyc; push_ls(32'h030201AA, c0 + 6, 1'b1); lsu(1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0); tick();

        // half store into the IO window, then read it back unsigned
        c0 = cyc;
        push_wr(32'h30000, 8'hEF, c0 + 1);
        push_wr(32'h30001, 8'hBE, c0 + 2);
        push_ls(32'h0, c0 + 3, 1'b0);
        lsu(1'b1, 2'b01, 1'b0, 32'h30000, 32'h1234BEEF);
        tick();
        c0 = cyc; push_ls(32'h0000BEEF, c0 + 4, 1'b1); lsu(1'b0, 2'b01, 1'b0, 32'h30000, 32'h0); tick();

        // simultaneous requests: LSU first, IF accepted in the cycle after ls_done
        c0 = cyc;
        push_ls(32'h33221180, c0 + 6, 1'b1);
        push_if(32'h93000013, c0 + 13);
        fork
            ifetch(32'h100);
            lsu(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        join
        tick();

        // reset in the middle of a word fetch
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid reset");
        bus.if_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("post reset mem_a", bus.mem_a, 32'd0);

        // stalled word read: rewound address must reappear after resume
        c0 = cyc;
        push_ls(32'hF00FC35A, -1, 1'b1);
        fork
            lsu(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
            begin
                tick(); tick(); tick();
                rdy = 1'b0;
                tick(); tick(); tick();
                rdy = 1'b1;
                seen = 1'b0;
                for (int k = 0; k < 12 && !bus.ls_done; k++) begin
                    @(negedge clk);
                    if (bus.mem_a == 32'h301) seen = 1'b1;
                end
                check("rewound addr reissued", 32'(seen), 32'd1);
            end
        join
        tick();

        // stalled word store: every byte written exactly once
        c0 = cyc;
        push_wr(32'h400, 8'hEF, c0 + 1);
        push_wr(32'h401, 8'hBE, -1);
        push_wr(32'h402, 8'hAD, -1);
        push_wr(32'h403, 8'hDE, -1);
        push_ls(32'h0, -1, 1'b0);
        fork
            lsu(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF);
            begin
                tick(); tick();
                rdy = 1'b0;
                tick(); tick();
                rdy = 1'b1;
            end
        join
        tick();
        c0 = cyc; push_ls(32'hDEADBEEF, c0 + 6, 1'b1); lsu(1'b0, 2'b10, 1'b0, 32'h400, 32'h0); tick();

`ifdef MEM_CTRL_IF_FLUSH_EN
        // flush in cycle 2 of a fetch; the held request is re-accepted in cycle 3
        c0 = cyc;
        push_if(32'h10000537, c0 + 9);
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        tick(); tick();
        flush = 1'b1;
        bus.if_addr = 32'h104;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush mem_a idle", bus.mem_a, 32'd0);
        wait_done(1'b0);
        bus.if_req = 1'b0;
        tick();
`endif

        tick(); tick(); tick();
        check("if queue drained", 32'(if_q.size()), 32'd0);
        check("ls queue drained", 32'(ls_q.size()), 32'd0);
        check("wr queue drained", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
